// File: rtl/md_unit_pkg.sv
// -----------------------------------------------------------------------------
// md_unit_pkg
// Shared EX-stage definitions: base opcodes, memory access kinds and sizes,
// and the multiply/divide operation encoding used by md_unit.
//   md_op_t bit 2 set = divide family; bit 0 selects remainder within it.
// -----------------------------------------------------------------------------
package md_unit_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_FENCE  = 7'b0001111,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10
  } mem_type_t;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_t;

  // 3'b011 is not listed; md_unit decodes it as a low-half multiply.
  typedef enum logic [2:0] {
    MD_MUL   = 3'b000,
    MD_MULH  = 3'b001,
    MD_MULHU = 3'b010,
    MD_DIV   = 3'b100,
    MD_MOD   = 3'b101,
    MD_DIVU  = 3'b110,
    MD_MODU  = 3'b111
  } md_op_t;

endpackage

// File: rtl/md_unit_if.sv
// -----------------------------------------------------------------------------
// md_unit_if
// Request/result handshake between one EX-stage lane (master) and its
// multiply/divide unit (slave).
//   flush              master->slave  cancel in-flight op, ignore same-cycle input
//   in_valid/in_ready  request handshake
//   in_op, in_src1, in_src2, in_tag   request payload
//   out_valid/out_ready result handshake
//   out_result, out_tag                result payload
//   busy               slave->master  unit not idle
// -----------------------------------------------------------------------------
interface md_unit_if
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  md_op_t           in_op;
  logic [WIDTH-1:0] in_src1;
  logic [WIDTH-1:0] in_src2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output flush, in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, busy
  );

  modport slave (
    input  flush, in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, busy
  );

endinterface

// File: rtl/md_div_core.sv
// -----------------------------------------------------------------------------
// md_div_core
// Iterative restoring divider on unsigned magnitudes, one quotient bit per
// cycle for WIDTH cycles.
//   clk, reset     clock, synchronous active-high reset
//   kill_i         abandon the current division
//   start_i        latch dividend_i/divisor_i and begin
//   done_o         high during the final iteration; quotient_o/remainder_o
//                  hold the final values from the following cycle
//   quotient_o     quotient magnitude (all ones for a zero divisor)
//   remainder_o    remainder magnitude (dividend for a zero divisor)
// -----------------------------------------------------------------------------
module md_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             kill_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = $clog2(WIDTH);

  logic             run_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quo_q;   // dividend bits shift out the top, quotient bits in the bottom
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Partial remainder stays below the divisor, so one extra bit suffices.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || kill_i) begin
      run_q <= 1'b0;
    end else if (start_i) begin
      run_q <= 1'b1;
    end else if (done_o) begin
      run_q <= 1'b0;
    end
  end

  // NOTE: pure datapath registers carry no reset; run_q qualifies them and
  // start_i always reloads them before use.
  always_ff @(posedge clk) begin
    if (start_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      dvs_q <= divisor_i;
      cnt_q <= CW'(WIDTH - 1);
    end else if (run_q) begin
      cnt_q <= cnt_q - CW'(1);
      if (!diff[WIDTH]) begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= shifted[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign done_o      = run_q && (cnt_q == '0);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit
// Multiply/divide execution unit for one EX lane: fixed-latency multiplier
// and iterative restoring divider behind a valid/ready handshake, one op in
// flight, result tag, flush cancellation.
//   clk, reset   clock, synchronous active-high reset
//   bus          md_unit_if.slave (request, result, flush, busy)
// Parameters: WIDTH (>=4), MUL_LAT (>=1), TAG_W.
// Build option: define MD_DIV_EARLY_OUT_EN to let divides with a zero divisor
// or |dividend| < |divisor| complete one cycle after accept.
// -----------------------------------------------------------------------------
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2,
  parameter int TAG_W   = 5
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  localparam int                MC_W     = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [MC_W-1:0]   MUL_LOAD = MC_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);

  // Full 2*WIDTH product; only MULH treats operands as signed.
  function automatic logic [WIDTH-1:0] mul_result(md_op_t op, logic [WIDTH-1:0] a,
                                                  logic [WIDTH-1:0] b);
    logic               sgn;
    logic [2*WIDTH-1:0] ea, eb, prod;
    sgn  = (op == MD_MULH);
    ea   = {{WIDTH{sgn & a[WIDTH-1]}}, a};
    eb   = {{WIDTH{sgn & b[WIDTH-1]}}, b};
    prod = ea * eb;
    return (op == MD_MULH || op == MD_MULHU) ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
  endfunction

  // Sign fixup; neg flags are only ever set for signed divide ops.
  function automatic logic [WIDTH-1:0] div_result(md_op_t op, logic [WIDTH-1:0] q,
                                                  logic [WIDTH-1:0] r, logic neg_a,
                                                  logic neg_b);
    logic [WIDTH-1:0] qs, rs;
    qs = (neg_a ^ neg_b) ? -q : q;
    rs = neg_a ? -r : r;
    return op[0] ? rs : qs;
  endfunction

  state_t           state_q, state_d;
  md_op_t           op_q;
  logic [WIDTH-1:0] src1_q, src2_q;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             neg1_q, neg2_q;
  logic [MC_W-1:0]  mul_cnt_q;
  logic [WIDTH-1:0] out_result_q, result_d;
  logic [TAG_W-1:0] out_tag_q;
  logic             result_we;

  logic             in_ready_c, accept;
  logic             in_div, in_signed_div, in_neg1, in_neg2;
  logic [WIDTH-1:0] in_mag1, in_mag2;
  logic             div_early;
  logic [WIDTH-1:0] div_early_result;
  logic             direct;
  logic [WIDTH-1:0] direct_result;
  state_t           entry_state;
  logic             div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  // Back-to-back issue is allowed in the cycle the previous result is taken.
  assign in_ready_c = ((state_q == S_IDLE) || (state_q == S_DONE && bus.out_ready)) && !bus.flush;
  assign accept     = bus.in_valid && in_ready_c;

  assign in_div        = bus.in_op[2];
  assign in_signed_div = in_div && !bus.in_op[1];
  assign in_neg1       = in_signed_div && bus.in_src1[WIDTH-1];
  assign in_neg2       = in_signed_div && bus.in_src2[WIDTH-1];
  assign in_mag1       = in_neg1 ? -bus.in_src1 : bus.in_src1;
  assign in_mag2       = in_neg2 ? -bus.in_src2 : bus.in_src2;

`ifdef MD_DIV_EARLY_OUT_EN
  // Trivial divides: the full restoring path would produce exactly these.
  assign div_early        = in_div && ((in_mag2 == '0) || (in_mag1 < in_mag2));
  assign div_early_result = div_result(bus.in_op, (in_mag2 == '0) ? '1 : '0, in_mag1,
                                       in_neg1, in_neg2);
`else
  assign div_early        = 1'b0;
  assign div_early_result = '0;
`endif

  // Ops that finish at the accept edge write the result from the input pins;
  // the pin-side multiplier folds away unless MUL_LAT is 1.
  assign direct        = in_div ? div_early : (MUL_LAT == 1);
  assign direct_result = in_div ? div_early_result
                                : mul_result(bus.in_op, bus.in_src1, bus.in_src2);
  assign entry_state   = direct ? S_DONE : (in_div ? S_DIV : S_MUL);

  md_div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk        (clk),
    .reset      (reset),
    .kill_i     (bus.flush),
    .start_i    (accept && in_div && !div_early),
    .dividend_i (in_mag1),
    .divisor_i  (in_mag2),
    .done_o     (div_done),
    .quotient_o (div_quo),
    .remainder_o(div_rem)
  );

  // NOTE: every variable driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    result_we = 1'b0;
    result_d  = out_result_q;
    tag_d     = tag_q;
    case (state_q)
      S_IDLE: ;
      S_MUL: begin
        if (mul_cnt_q == '0) begin
          state_d   = S_DONE;
          result_we = 1'b1;
          result_d  = mul_result(op_q, src1_q, src2_q);
        end
      end
      S_DIV:  if (div_done) state_d = S_FIX;
      S_FIX: begin
        state_d   = S_DONE;
        result_we = 1'b1;
        result_d  = div_result(op_q, div_quo, div_rem, neg1_q, neg2_q);
      end
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      state_d = entry_state;
      if (direct) begin
        result_we = 1'b1;
        result_d  = direct_result;
        tag_d     = bus.in_tag;
      end
    end
    // Flush wins over everything, including a same-cycle result write.
    if (bus.flush) begin
      state_d   = S_IDLE;
      result_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      state_q <= state_d;
      if (result_we) begin
        out_result_q <= result_d;
        out_tag_q    <= tag_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q      <= bus.in_op;
      src1_q    <= bus.in_src1;
      src2_q    <= bus.in_src2;
      tag_q     <= bus.in_tag;
      neg1_q    <= in_neg1;
      neg2_q    <= in_neg2;
      mul_cnt_q <= MUL_LOAD;
    end else if (state_q == S_MUL) begin
      mul_cnt_q <= mul_cnt_q - MC_W'(1);
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.out_result = out_result_q;
  assign bus.out_tag    = out_tag_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multiply/divide execution unit for one issue lane of the EX stage. It replaces the vendor multiplier and divider IP with in-house RTL: a fixed-latency multiplier and an iterative restoring divider behind a valid/ready handshake, with a result tag and flush cancellation. The EX stage instantiates one per lane and stalls the lane while `busy` is high or `out_valid` is low.

## Interface
- `WIDTH`, 32: operand and result width; must be ≥ 4.
- `MUL_LAT`, 2: accept-to-result latency of multiply ops in cycles; must be ≥ 1.
- `TAG_W`, 5: width of the opaque tag (dest reg) carried with each op.

- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  cancels any in-flight op; same-cycle input is ignored.
- `in_valid`  in  1  op request.
- `in_ready`  out  1  unit can accept; reset 1.
- `in_op`  in  3  `md_op_t`.
- `in_src1`, `in_src2`  in  WIDTH  dividend/multiplicand, divisor/multiplier.
- `in_tag`  in  TAG_W  returned unchanged on `out_tag`.
- `out_valid`  out  1  result valid; reset 0.
- `out_ready`  in  1  consumer takes result.
- `out_result`  out  WIDTH  result; reset 0.
- `out_tag`  out  TAG_W  reset 0.
- `busy`  out  1  state ≠ IDLE; reset 0.

## Operation
- `md_op_t` encoding: MD_MUL=000, MD_MULH=001, MD_MULHU=010, MD_DIV=100, MD_MOD=101, MD_DIVU=110, MD_MODU=111. Bit 2 set means divide. Encoding 011 is treated as MD_MUL.
- One op in flight. FSM states: IDLE, MUL, DIV, FIX, DONE.
- Accept occurs when `in_valid && in_ready && !flush`. `in_ready = (IDLE || (DONE && out_ready)) && !flush`. This allows back-to-back issue on the result-consume cycle.
- On accept, src/op/tag are latched.
  - MUL ops go to MUL, which counts MUL_LAT-1 cycles, then goes to DONE. If MUL_LAT=1, the op goes straight to DONE.
  - DIV ops go to DIV.
- MUL: the product is 2·WIDTH bits.
  - MD_MULH sign-extends both operands; MD_MULHU and MD_MUL zero-extend them.
  - MD_MUL returns the low half; MD_MULH and MD_MULHU return the high half.
- DIV: magnitudes are taken for signed ops.
  - The divider is restoring, one quotient bit per cycle, for WIDTH cycles (counter WIDTH-1 down to 0).
  - FIX applies signs: quotient is negated if the operand signs differ; remainder takes the dividend's sign. Then the FSM goes to DONE.
- Divide by zero: quotient is all-ones magnitude and remainder is the dividend magnitude, with the normal sign fixup applied afterwards.
- Signed MIN/−1: quotient MIN, remainder 0.
- DONE: `out_valid`=1 and result/tag are held stable until `out_ready`. Then the FSM returns to IDLE, or re-enters MUL/DIV if a new op is accepted in the same cycle.
- Flush in any state: the FSM is in IDLE next cycle, `out_valid`=0, and the result register is not updated.
- Reset has the same effect as flush and also clears `out_result` and `out_tag`.

## Timing
- Accept edge is cycle 0. `out_valid` is first high in cycle L.
- L = MUL_LAT for multiply ops.
- L = WIDTH+2 for divide ops (WIDTH DIV cycles plus 1 FIX cycle); L = 34 at default WIDTH.
- If `out_ready`=1 in cycle L, the result is consumed in cycle L.
- Under `out_ready` back-pressure, outputs hold with no change and no loss.
- `out_valid` never asserts in the cycle after flush or reset.

## Configuration
- `MD_DIV_EARLY_OUT_EN`:
  - Defined: a divide op with divisor 0, or with |dividend| < |divisor|, skips DIV and FIX and enters DONE directly, so L=1. Results are bit-identical to the full path (e.g. 3/5 → q=0, r=3; x/0 → q=all-ones with sign fixup, r=x).
  - Undefined: every divide op takes WIDTH+2 cycles.

## Structure
- `md_op_t` and the MD_* constants go in the shared definitions package, next to `opcode_t`.
- `mem_type_t` and `mem_size_t` stay where they are; nothing else is added to the package.
- One sub-module, `md_div_core`: the iterative restoring divider datapath (WIDTH parameter, start/done, quotient/remainder magnitudes). The FSM, sign handling and multiplier stay in `md_unit`.

## Test plan
- MD_MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE with `out_valid` at cycle 2; MD_MULH on the same operands → 0x00000000; MD_MUL on the same operands → 0x00000001.
- MD_DIV 7/−2 → 0xFFFFFFFD; MD_MOD 7,−2 → 1; MD_MOD −7,2 → 0xFFFFFFFF; MD_DIV 0x80000000/0xFFFFFFFF → 0x80000000; each at cycle 34 without early-out.
- MD_DIVU 5/0 → 0xFFFFFFFF and MD_MODU 5/0 → 5. With `MD_DIV_EARLY_OUT_EN` these appear at cycle 1; MD_DIVU 3/5 → 0 at cycle 1.
- Hold `out_ready`=0 for 10 cycles after a result → `out_valid`, result and tag stay constant and `in_ready`=0. Raise `out_ready` with a new `in_valid` → both accepted in the same cycle.
- Flush at cycle 10 of a divide → IDLE and `out_valid`=0 from cycle 11. A new MD_MUL accepted at cycle 11 returns the correct product and tag at cycle 13.
- Reset asserted mid-multiply → next cycle `busy`=0, `in_ready`=1, `out_valid`=0, `out_result`=0.
